button_press_counter: RTL and testbench



---
 rtl/button_press_counter.sv | 180 ++++++++++++++++++
 tb/tb_button_press_counter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_press_counter.sv
`timescale 1ns/1ps
// button_press_counter
//   Counts debounced presses of an active-low mechanical push button and
//   shows the running count on the board LEDs.
//   Chain: 2-flop synchronizer -> debounce FSM -> wrapping press counter.
//
// Ports
//   clk          12 MHz board oscillator, the only clock
//   rst_btn      asynchronous active-low reset (reset button)
//   cnt_btn      raw asynchronous push button, active-low (0 = pressed)
//   led          current press count, registered, wraps to 0
//   press_pulse  one-cycle strobe, high on the first cycle led shows a new count
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, holding the button auto-repeats the count after
//   REPEAT_DELAY_CYCLES, then every REPEAT_RATE_CYCLES. When undefined, a
//   held button counts exactly once.
//
// Debounce FSM
//   state        | meaning
//   IDLE         | button released and stable
//   PRESS_WAIT   | low seen, waiting for DEBOUNCE_CYCLES stable low samples
//   PRESSED      | press accepted and counted, button held
//   RELEASE_WAIT | high seen, waiting for DEBOUNCE_CYCLES stable high samples
module button_press_counter #(
  parameter int unsigned DEBOUNCE_CYCLES     = 120000,
  parameter int unsigned CNT_WIDTH           = 4,
  parameter int unsigned REPEAT_DELAY_CYCLES = 6000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 1200000
) (
  input  logic                 clk,
  input  logic                 rst_btn,
  input  logic                 cnt_btn,
  output logic [CNT_WIDTH-1:0] led,
  output logic                 press_pulse
);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h000F_FFFF) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..2^20-1");
  end
  if (REPEAT_DELAY_CYCLES < 2 || REPEAT_DELAY_CYCLES > 32'h007F_FFFF ||
      REPEAT_RATE_CYCLES < 2 || REPEAT_RATE_CYCLES > 32'h007F_FFFF) begin : g_bad_repeat
    $error("REPEAT_*_CYCLES must be in 2..2^23-1");
  end

  // The edge that moves into a WAIT state has already consumed the first
  // stable sample, so the wait completes when the timer reaches D-2. This
  // makes the first-low-sample to led-update latency exactly D edges.
  localparam logic [19:0] DB_LAST   = 20'(DEBOUNCE_CYCLES - 2);
  localparam logic [19:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [19:0]            timer_q, timer_d;
  logic [CNT_WIDTH-1:0]   led_q, led_d;
  logic                   pulse_q, pulse_d;
  logic                   sync1_q, btn_s_q;
  logic                   count_en;

`ifdef AUTO_REPEAT_EN
  localparam logic [22:0] RPT_DELAY_LAST = 23'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [22:0] RPT_RATE_LAST  = 23'(REPEAT_RATE_CYCLES - 1);

  logic [22:0] rpt_q, rpt_d;
  logic        rpt_fast_q, rpt_fast_d;   // first repeat already issued
`endif

  // Synchronizer resets to "released" so a held button is seen as a fresh press.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      sync1_q <= 1'b1;
      btn_s_q <= 1'b1;
    end else begin
      sync1_q <= cnt_btn;
      btn_s_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state_q <= IDLE;
      timer_q <= '0;
      led_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
      pulse_q <= pulse_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      rpt_q      <= '0;
      rpt_fast_q <= 1'b0;
    end else begin
      rpt_q      <= rpt_d;
      rpt_fast_q <= rpt_fast_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = (timer_q == TIMER_MAX) ? timer_q : timer_q + 20'd1;
    count_en = 1'b0;
`ifdef AUTO_REPEAT_EN
    rpt_d      = rpt_q;
    rpt_fast_d = rpt_fast_q;
`endif

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!btn_s_q) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (btn_s_q) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d  = PRESSED;
          timer_d  = '0;
          count_en = 1'b1;
        end
      end
      PRESSED: begin
        timer_d = '0;
        if (btn_s_q) begin
          state_d = RELEASE_WAIT;
        end
`ifdef AUTO_REPEAT_EN
        else if (rpt_q == (rpt_fast_q ? RPT_RATE_LAST : RPT_DELAY_LAST)) begin
          count_en   = 1'b1;
          rpt_d      = '0;
          rpt_fast_d = 1'b1;
        end else begin
          rpt_d = rpt_q + 23'd1;
        end
`endif
      end
      RELEASE_WAIT: begin
        if (!btn_s_q) begin
          state_d = PRESSED;
          timer_d = '0;
        end else if (timer_q == DB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

`ifdef AUTO_REPEAT_EN
    // Any cycle not spent continuously in PRESSED restarts the initial delay.
    if (state_q != PRESSED || state_d != PRESSED) begin
      rpt_d      = '0;
      rpt_fast_d = 1'b0;
    end
`endif

    led_d   = count_en ? led_q + 1'b1 : led_q;
    pulse_d = count_en;
  end

  assign led         = led_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_press_counter.sv
`timescale 1ns/1ps
module tb_button_press_counter;

  logic       clk     = 1'b0;
  logic       rst_btn = 1'b1;
  logic       cnt_btn = 1'b1;
  logic [3:0] led;
  logic       press_pulse;

  int checks    = 0;
  int failures  = 0;
  int pulse_cnt = 0;
  int double_cnt = 0;
  logic prev_pulse = 1'b0;

  button_press_counter #(
    .DEBOUNCE_CYCLES    (4),
    .CNT_WIDTH          (4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst_btn    (rst_btn),
    .cnt_btn    (cnt_btn),
    .led        (led),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse) pulse_cnt++;
    if (press_pulse && prev_pulse) double_cnt++;
    prev_pulse = press_pulse;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_btn = 1'b0;
    cnt_btn = 1'b1;
    tick(2);
    rst_btn = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    int base;
    cnt_btn = 1'b0;
    #2 rst_btn = 1'b0;
    tick(3);
    checks++;
    if (led !== 4'd0) begin failures++; $display("FAIL reset_led actual=%0d required=0", led); end
    checks++;
    if (press_pulse !== 1'b0) begin failures++; $display("FAIL reset_pulse actual=%b required=0", press_pulse); end
    rst_btn = 1'b1;
    base = pulse_cnt;
    tick(5);
    checks++;
    if (led !== 4'd0) begin failures++; $display("FAIL reset_held_early actual=%0d required=0", led); end
    tick(1);
    checks++;
    if (led !== 4'd1 || press_pulse !== 1'b1) begin
      failures++; $display("FAIL reset_held_count led=%0d pulse=%b required led=1 pulse=1", led, press_pulse);
    end
    tick(1);
    checks++;
    if (press_pulse !== 1'b0) begin failures++; $display("FAIL reset_held_pulse_drop actual=%b required=0", press_pulse); end
    tick(10);
    cnt_btn = 1'b1;
    tick(10);
    checks++;
    if (led !== 4'd1 || pulse_cnt - base != 1) begin
      failures++; $display("FAIL reset_held_once led=%0d pulses=%0d required led=1 pulses=1", led, pulse_cnt - base);
    end
  endtask

  task automatic test_clean_press();
    int base;
    apply_reset();
    base = pulse_cnt;
    cnt_btn = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (i == 5) begin
        checks++;
        if (led !== 4'd0) begin failures++; $display("FAIL clean_edge5 actual=%0d required=0", led); end
      end
      if (i == 6) begin
        checks++;
        if (led !== 4'd1 || press_pulse !== 1'b1) begin
          failures++; $display("FAIL clean_edge6 led=%0d pulse=%b required led=1 pulse=1", led, press_pulse);
        end
      end
      if (i == 7) begin
        checks++;
        if (press_pulse !== 1'b0) begin failures++; $display("FAIL clean_edge7_pulse actual=%b required=0", press_pulse); end
      end
    end
    cnt_btn = 1'b1;
    tick(12);
    checks++;
    if (led !== 4'd1 || pulse_cnt - base != 1) begin
      failures++; $display("FAIL clean_final led=%0d pulses=%0d required led=1 pulses=1", led, pulse_cnt - base);
    end
  endtask

  task automatic test_bounce();
    logic press_pat [7]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic release_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int base;
    apply_reset();
    base = pulse_cnt;
    for (int i = 0; i < 7; i++) begin
      cnt_btn = press_pat[i];
      tick(1);
    end
    tick(1);
    checks++;
    if (led !== 4'd0) begin failures++; $display("FAIL bounce_edge8 actual=%0d required=0", led); end
    tick(1);
    checks++;
    if (led !== 4'd1 || press_pulse !== 1'b1) begin
      failures++; $display("FAIL bounce_edge9 led=%0d pulse=%b required led=1 pulse=1", led, press_pulse);
    end
    tick(10);
    for (int i = 0; i < 6; i++) begin
      cnt_btn = release_pat[i];
      tick(1);
    end
    tick(10);
    checks++;
    if (led !== 4'd1 || pulse_cnt - base != 1) begin
      failures++; $display("FAIL bounce_release led=%0d pulses=%0d required led=1 pulses=1", led, pulse_cnt - base);
    end
  endtask

  task automatic test_glitches();
    int base;
    apply_reset();
    base = pulse_cnt;
    for (int w = 1; w <= 3; w++) begin
      cnt_btn = 1'b0;
      tick(w);
      cnt_btn = 1'b1;
      tick(10);
      checks++;
      if (led !== 4'd0 || pulse_cnt != base) begin
        failures++; $display("FAIL glitch_w%0d led=%0d pulses=%0d required led=0 pulses=0", w, led, pulse_cnt - base);
      end
    end
  endtask

  task automatic test_wrap();
    int base;
    logic [3:0] exp_led;
    apply_reset();
    base = pulse_cnt;
    exp_led = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cnt_btn = 1'b0;
      tick(8);
      exp_led = exp_led + 4'd1;
      checks++;
      if (led !== exp_led) begin failures++; $display("FAIL wrap_press%0d actual=%0d required=%0d", i + 1, led, exp_led); end
      cnt_btn = 1'b1;
      tick(8);
    end
    checks++;
    if (led !== 4'd0 || pulse_cnt - base != 16) begin
      failures++; $display("FAIL wrap_total led=%0d pulses=%0d required led=0 pulses=16", led, pulse_cnt - base);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cnt_btn = 1'b0;
    tick(8);
    cnt_btn = 1'b1;
    tick(8);
    checks++;
    if (led !== 4'd1) begin failures++; $display("FAIL mid_setup actual=%0d required=1", led); end
    // press and reset while the debounce timer sits at 2
    cnt_btn = 1'b0;
    tick(5);
    rst_btn = 1'b0;
    #1;
    checks++;
    if (led !== 4'd0 || press_pulse !== 1'b0) begin
      failures++; $display("FAIL mid_wait_reset led=%0d pulse=%b required led=0 pulse=0", led, press_pulse);
    end
    tick(2);
    rst_btn = 1'b1;
    tick(5);
    checks++;
    if (led !== 4'd0) begin failures++; $display("FAIL mid_rerun_early actual=%0d required=0", led); end
    tick(1);
    checks++;
    if (led !== 4'd1 || press_pulse !== 1'b1) begin
      failures++; $display("FAIL mid_rerun_count led=%0d pulse=%b required led=1 pulse=1", led, press_pulse);
    end
    // reset on the pulse cycle itself
    rst_btn = 1'b0;
    #1;
    checks++;
    if (led !== 4'd0 || press_pulse !== 1'b0) begin
      failures++; $display("FAIL mid_pulse_reset led=%0d pulse=%b required led=0 pulse=0", led, press_pulse);
    end
    tick(2);
    rst_btn = 1'b1;
    tick(6);
    checks++;
    if (led !== 4'd1 || press_pulse !== 1'b1) begin
      failures++; $display("FAIL mid_after_pulse_reset led=%0d pulse=%b required led=1 pulse=1", led, press_pulse);
    end
    cnt_btn = 1'b1;
    tick(10);
    checks++;
    if (led !== 4'd1) begin failures++; $display("FAIL mid_final actual=%0d required=1", led); end
  endtask

`ifdef AUTO_REPEAT_EN
  task automatic test_hold();
    logic [3:0] exp_led;
    apply_reset();
    cnt_btn = 1'b0;
    tick(6);
    exp_led = 4'd1;
    checks++;
    if (led !== exp_led) begin failures++; $display("FAIL repeat_first actual=%0d required=1", led); end
    for (int k = 1; k <= 60; k++) begin
      tick(1);
      if (k == 20 || k == 28 || k == 36 || k == 44 || k == 52 || k == 60) exp_led = exp_led + 4'd1;
      checks++;
      if (led !== exp_led) begin failures++; $display("FAIL repeat_k%0d actual=%0d required=%0d", k, led, exp_led); end
    end
    cnt_btn = 1'b1;
    tick(30);
    checks++;
    if (led !== 4'd7) begin failures++; $display("FAIL repeat_release actual=%0d required=7", led); end
  endtask
`else
  task automatic test_hold();
    int base;
    apply_reset();
    base = pulse_cnt;
    cnt_btn = 1'b0;
    tick(66);
    checks++;
    if (led !== 4'd1 || pulse_cnt - base != 1) begin
      failures++; $display("FAIL hold_once led=%0d pulses=%0d required led=1 pulses=1", led, pulse_cnt - base);
    end
    cnt_btn = 1'b1;
    tick(10);
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitches();
    test_wrap();
    test_reset_mid();
    test_hold();
    checks++;
    if (double_cnt != 0) begin failures++; $display("FAIL pulse_back_to_back actual=%0d required=0", double_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
